uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   UART receiver, 8N1, LSB first; receive-side counterpart of the team's uart_tx.
//   Synchronises the asynchronous rx line and finds the start bit on a falling edge.
//   Samples each bit at mid-period and delivers one byte per frame with a 1-cycle strobe.
//   Sits between the board serial pin and the DHT11/cold-storage command logic.
// PARAMETERS
//   CLK_FREQ   100_000_000  system clock in Hz
//   BAUD_RATE  9600         line rate in bit/s
//   BIT_PERIOD (local) CLK_FREQ/BAUD_RATE = 10416 clocks per bit
//   HALF_BIT   (local) BIT_PERIOD/2 = 5208 clocks
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst        in   1  synchronous reset, active-high
//   rx         in   1  serial input, asynchronous, idle HIGH
//   rx_data    out  8  last correctly framed byte, held until the next good frame
//   rx_valid   out  1  1-cycle strobe: rx_data updated this cycle
//   rx_busy    out  1  high while a frame is being received (state != IDLE)
//   frame_err  out  1  1-cycle strobe: stop bit sampled LOW, byte discarded
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge): state=IDLE, rx_data=0, rx_valid=0, rx_busy=0,
//     frame_err=0, counters=0, both sync FFs and edge reg preset to 1 (idle line).
//     Reset mid-frame aborts the frame with no strobe. The next frame needs a fresh falling edge.
//   Input: 2-FF synchroniser -> rx_s; edge reg rx_d <= rx_s; fall = rx_d & ~rx_s.
//   Counter: 16-bit clk_cnt (covers BIT_PERIOD-1 = 10415); bit_idx 3-bit.
//   FSM:
//     IDLE : on fall -> START, clk_cnt=0. A low level alone never triggers (blocks re-arm
//            during a break or after a framing error until the line returns HIGH).
//     START: at clk_cnt==HALF_BIT-1 sample rx_s. If 0 -> DATA, clk_cnt=0, bit_idx=0.
//            If 1 -> IDLE (glitch reject, no strobe).
//     DATA : at clk_cnt==BIT_PERIOD-1 shift rx_s into shift[7] (shift right), clk_cnt=0.
//            Increment bit_idx. After bit_idx==7 is sampled -> STOP.
//     STOP : at clk_cnt==BIT_PERIOD-1 sample rx_s. If 1: rx_data<=shift, rx_valid=1.
//            If 0: frame_err=1, rx_data unchanged. Either way -> IDLE.
//   Sampling therefore lands at mid-bit for start, data 0..7 and stop.
//   Latency: strobe is asserted HALF_BIT + 9*BIT_PERIOD clocks after the cycle `fall` is seen.
//     rx is delayed 2 clocks by the synchroniser and 1 clock by the edge register.
//   Strobes are registered and last exactly 1 cycle. rx_valid and frame_err are never high together.
//   No back-pressure: the consumer must take rx_data before the next rx_valid. rx_data is stable
//     for at least one full frame.
//   Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge that follows the
//     stop bit is caught.
//   rx_busy is combinational from state (state != IDLE), glitch-free since state is registered.
// STRUCTURE
//   uart_pkg: FSM state encodings (IDLE/START/DATA/STOP, 2-bit) and a
//     bit_period(clk,baud) function shared with uart_tx.
//   Sub-module uart_bit_sync: 2-FF synchroniser with reset value 1. Reusable for other
//     asynchronous pins (DHT11 data line).
//   Remaining datapath and FSM stay in a single always block plus output registers.
// TESTING (bench uses CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> BIT_PERIOD=10, HALF_BIT=5)
//   1 Send 0xA5 8N1 -> one rx_valid pulse, rx_data=8'hA5, frame_err never high, rx_busy
//     high for the frame.
//   2 Send 0x00 then 0xFF back-to-back (stop bit directly followed by start) -> two rx_valid
//     pulses, rx_data 8'h00 then 8'hFF.
//   3 Drive rx low for 3 clocks then high -> returns to IDLE, no rx_valid, no frame_err,
//     rx_data unchanged.
//   4 Send 0x3C with stop bit forced LOW, then hold rx low 30 clocks -> one frame_err pulse.
//     rx_data keeps the previous value and there is no retrigger until rx goes high.
//     A following 0x3C is received normally.
//   5 Assert rst for 1 cycle mid-byte (after bit 3) -> outputs return to reset values and no
//     strobe occurs. A next clean frame 0x5A is received correctly.
//   6 Send 0x81 with a bit period 4% fast and then 4% slow -> rx_data=8'h81 both times.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART FSM state encoding and bit-period helper.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  function automatic int unsigned bit_period(input int unsigned clk_hz,
                                             input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : uart_bit_sync
// Brief  : Two-flop synchroniser for an asynchronous single-bit input.
// Rev    : 1.0  initial release
// ============================================================================
module uart_bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : uart_rx
// Brief  : 8N1 UART receiver, LSB first, mid-bit sampling, 1-cycle strobes.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int unsigned c_BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int unsigned c_HALF_BIT   = c_BIT_PERIOD / 2;
  localparam logic [15:0] c_BIT_LAST   = 16'(c_BIT_PERIOD - 1);
  localparam logic [15:0] c_HALF_LAST  = 16'(c_HALF_BIT - 1);

  uart_state_t r_state;
  uart_state_t w_state_nxt;
  logic [15:0] r_clk_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_err;
  logic        r_rx_d;
  logic        w_rx_s;
  logic        w_fall;
  logic        w_cnt_clr;
  logic        w_shift_en;
  logic        w_valid_nxt;
  logic        w_ferr_nxt;

  uart_bit_sync #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  // Edge-triggered start: a line held low (break, bad stop) never re-arms the FSM.
  assign w_fall = r_rx_d & ~w_rx_s;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_clr = 1'b1;
        if (w_fall) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (r_clk_cnt == c_HALF_LAST) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_clk_cnt == c_BIT_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        // Leaving mid-stop-bit lets an immediately following start edge be caught.
        if (r_clk_cnt == c_BIT_LAST) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_valid_nxt = w_rx_s;
          w_ferr_nxt  = ~w_rx_s;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_clk_cnt   <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_d      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_rx_d      <= w_rx_s;
      r_clk_cnt   <= w_cnt_clr ? 16'd0 : r_clk_cnt + 16'd1;
      r_rx_valid  <= w_valid_nxt;
      r_frame_err <= w_ferr_nxt;
      if (r_state == ST_START) begin
        r_bit_idx <= 3'd0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {w_rx_s, r_shift[7:1]};
      end
      if (w_valid_nxt) begin
        r_rx_data <= r_shift;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign rx_busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire
